// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between ID-stage control and the forwarding/hazard unit.
// The FWD_ID_BYPASS_EN build adds the ID write-through bypass selects.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] id_rs1_i;
    logic [REG_ADDR_W-1:0] id_rs2_i;
    logic [REG_ADDR_W-1:0] id_rd_i;
    logic                  id_regwrite_i;
    logic                  id_memread_i;
    logic                  flush_i;
    logic [1:0]            fwd_a_o;
    logic [1:0]            fwd_b_o;
    logic                  stall_o;
    logic [REG_ADDR_W-1:0] ex_rd_o;

`ifdef FWD_ID_BYPASS_EN
    logic                  id_byp_a_o;
    logic                  id_byp_b_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, ex_rd_o, id_byp_a_o, id_byp_b_o
    );
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, ex_rd_o, id_byp_a_o, id_byp_b_o
    );
`else
    modport master (
        output id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, ex_rd_o
    );
    modport slave (
        input  id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, ex_rd_o
    );
`endif
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding selects and load-use stall for the 5-stage pipeline.
// Define FWD_ID_BYPASS_EN to also drive the ID register-file write-through bypass.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int X0_HARDWIRED = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fwd_hazard_ctrl_if.slave bus
);
    typedef logic [REG_ADDR_W-1:0] reg_t;

    reg_t ex_rs1;
    reg_t ex_rs2;
    reg_t ex_rd;
    logic ex_regwrite;
    logic ex_memread;
    reg_t mem_rd;
    logic mem_regwrite;
    reg_t wb_rd;
    logic wb_regwrite;
    logic bubble;

    // A write to x0 is architecturally discarded, so it must not look like a producer.
    function automatic logic live(input reg_t rd);
        return (X0_HARDWIRED == 0) || (rd != '0);
    endfunction

    function automatic logic [1:0] select(input reg_t src, input reg_t mrd, input logic mrw,
                                          input reg_t wrd, input logic wrw);
        if (mrw && live(mrd) && (mrd == src)) begin
            return 2'b10;
        end else if (wrw && live(wrd) && (wrd == src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        bus.fwd_a_o = select(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        bus.fwd_b_o = select(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        bus.stall_o = ex_memread && live(ex_rd) &&
                      ((ex_rd == bus.id_rs1_i) || (ex_rd == bus.id_rs2_i));
        bus.ex_rd_o = ex_rd;
    end

`ifdef FWD_ID_BYPASS_EN
    always_comb begin
        bus.id_byp_a_o = wb_regwrite && live(wb_rd) && (wb_rd == bus.id_rs1_i);
        bus.id_byp_b_o = wb_regwrite && live(wb_rd) && (wb_rd == bus.id_rs2_i);
    end
`endif

    // Stall and flush both collapse to one bubble; the squashed instruction never reaches EX.
    assign bubble = bus.stall_o || bus.flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            mem_rd       <= '0;
            mem_regwrite <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
        end else begin
            if (bubble) begin
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
            end else begin
                ex_rs1      <= bus.id_rs1_i;
                ex_rs2      <= bus.id_rs2_i;
                ex_rd       <= bus.id_rd_i;
                ex_regwrite <= bus.id_regwrite_i;
                ex_memread  <= bus.id_memread_i;
            end
            mem_rd       <= ex_rd;
            mem_regwrite <= ex_regwrite;
            wb_rd        <= mem_rd;
            wb_regwrite  <= mem_regwrite;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-history model. Define FWD_ID_BYPASS_EN for the bypass build.
module tb_fwd_hazard_ctrl;
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    // hist[2] is the instruction in EX, hist[1] in MEM, hist[0] in WB.
    instr_t hist[$];
    instr_t cur_id;
    logic   cur_flush;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(5)) bus();

    fwd_hazard_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic init_model();
        instr_t b;
        b = '0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(b);
    endtask

    // The nearest older instruction writing the source register supplies it.
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        instr_t p;
        for (int age = 1; age <= 2; age++) begin
            p = hist[2-age];
            if (p.rw && p.rd != 5'd0 && p.rd == src) return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall(input instr_t id);
        instr_t p;
        p = hist[2];
        return p.mr && p.rd != 5'd0 && (p.rd == id.rs1 || p.rd == id.rs2);
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        cur_id.rs1 = rs1; cur_id.rs2 = rs2; cur_id.rd = rd; cur_id.rw = rw; cur_id.mr = mr;
        cur_flush = fl;
        bus.id_rs1_i = rs1; bus.id_rs2_i = rs2; bus.id_rd_i = rd;
        bus.id_regwrite_i = rw; bus.id_memread_i = mr; bus.flush_i = fl;
        #1;
    endtask

    task automatic tick();
        instr_t b;
        b = '0;
        if (model_stall(cur_id) || cur_flush) hist.push_back(b);
        else hist.push_back(cur_id);
        hist.delete(0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (bus.fwd_a_o !== 2'b00) begin failures++; $display("[TB] FAIL rst_hold_fwd_a got=%b exp=00", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b00) begin failures++; $display("[TB] FAIL rst_hold_fwd_b got=%b exp=00", bus.fwd_b_o); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.ex_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL rst_hold_ex_rd got=%0d exp=0", bus.ex_rd_o); end
        @(negedge clk);
        rst = 1'b0;
        // add x5 ; lw x6,(x5) ; consumer of x6 waiting in ID
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0); tick();
        drive(5'd6, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.fwd_a_o !== 2'b10) begin failures++; $display("[TB] FAIL pre_rst_fwd_a got=%b exp=10", bus.fwd_a_o); end
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("[TB] FAIL pre_rst_stall got=%b exp=1", bus.stall_o); end
        rst = 1'b1;
        init_model();
        #1;
        checks++; if (bus.fwd_a_o !== 2'b00) begin failures++; $display("[TB] FAIL async_rst_fwd_a got=%b exp=00", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b00) begin failures++; $display("[TB] FAIL async_rst_fwd_b got=%b exp=00", bus.fwd_b_o); end
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.ex_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL async_rst_ex_rd got=%0d exp=0", bus.ex_rd_o); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_exmem_forward();
        drain();
        drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.fwd_a_o !== 2'b10) begin failures++; $display("[TB] FAIL exmem_fwd_a got=%b exp=10", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b00) begin failures++; $display("[TB] FAIL exmem_fwd_b got=%b exp=00", bus.fwd_b_o); end
        checks++; if (bus.ex_rd_o !== 5'd8) begin failures++; $display("[TB] FAIL exmem_ex_rd got=%0d exp=8", bus.ex_rd_o); end
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.fwd_a_o !== 2'b00) begin failures++; $display("[TB] FAIL memwb_fwd_a got=%b exp=00", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b01) begin failures++; $display("[TB] FAIL memwb_fwd_b got=%b exp=01", bus.fwd_b_o); end
        tick();
    endtask

    task automatic test_priority();
        drain();
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd7, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.fwd_a_o !== 2'b10) begin failures++; $display("[TB] FAIL prio_fwd_a got=%b exp=10", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b10) begin failures++; $display("[TB] FAIL prio_fwd_b got=%b exp=10", bus.fwd_b_o); end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        drive(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0); tick();
        drive(5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%b exp=1", bus.stall_o); end
        checks++; if (bus.ex_rd_o !== 5'd9) begin failures++; $display("[TB] FAIL lu_ex_rd got=%0d exp=9", bus.ex_rd_o); end
        tick();
        drive(5'd1, 5'd9, 5'd12, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL lu_one_cycle got=%b exp=0", bus.stall_o); end
        checks++; if (bus.ex_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL lu_bubble_rd got=%0d exp=0", bus.ex_rd_o); end
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.ex_rd_o !== 5'd12) begin failures++; $display("[TB] FAIL lu_add_rd got=%0d exp=12", bus.ex_rd_o); end
        checks++; if (bus.fwd_b_o !== 2'b01) begin failures++; $display("[TB] FAIL lu_fwd_b got=%b exp=01", bus.fwd_b_o); end
        checks++; if (bus.fwd_a_o !== 2'b00) begin failures++; $display("[TB] FAIL lu_fwd_a got=%b exp=00", bus.fwd_a_o); end
        tick();
    endtask

    task automatic test_x0_flush();
        drain();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.fwd_a_o !== 2'b00) begin failures++; $display("[TB] FAIL x0_fwd_a got=%b exp=00", bus.fwd_a_o); end
        checks++; if (bus.fwd_b_o !== 2'b00) begin failures++; $display("[TB] FAIL x0_fwd_b got=%b exp=00", bus.fwd_b_o); end
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL x0_load_stall got=%b exp=0", bus.stall_o); end
        tick();
        drain();
        drive(5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 1'b0); tick();
        drive(5'd14, 5'd0, 5'd15, 1'b1, 1'b0, 1'b1);
        checks++; if (bus.stall_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_lu_stall got=%b exp=1", bus.stall_o); end
        tick();
        drive(5'd14, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.stall_o !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_second_stall got=%b exp=0", bus.stall_o); end
        checks++; if (bus.ex_rd_o !== 5'd0) begin failures++; $display("[TB] FAIL flush_bubble_rd got=%0d exp=0", bus.ex_rd_o); end
        tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.ex_rd_o !== 5'd15) begin failures++; $display("[TB] FAIL flush_refetch_rd got=%0d exp=15", bus.ex_rd_o); end
        checks++; if (bus.fwd_a_o !== 2'b01) begin failures++; $display("[TB] FAIL flush_refetch_fwd_a got=%b exp=01", bus.fwd_a_o); end
        tick();
    endtask

`ifdef FWD_ID_BYPASS_EN
    task automatic test_bypass();
        drain();
        drive(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.id_byp_a_o !== 1'b1) begin failures++; $display("[TB] FAIL byp_a_hit got=%b exp=1", bus.id_byp_a_o); end
        checks++; if (bus.id_byp_b_o !== 1'b0) begin failures++; $display("[TB] FAIL byp_b_miss got=%b exp=0", bus.id_byp_b_o); end
        tick();
        drive(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.id_byp_a_o !== 1'b0) begin failures++; $display("[TB] FAIL byp_a_norw got=%b exp=0", bus.id_byp_a_o); end
        checks++; if (bus.id_byp_b_o !== 1'b0) begin failures++; $display("[TB] FAIL byp_b_norw got=%b exp=0", bus.id_byp_b_o); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic held;
        instr_t n;
        logic fl;
        logic [1:0] ea, eb;
        logic es;
        held = 1'b0;
        n = '0;
        drain();
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                n.rs1 = 5'($urandom_range(0, 3));
                n.rs2 = 5'($urandom_range(0, 3));
                n.rd  = 5'($urandom_range(0, 3));
                n.mr  = ($urandom_range(0, 2) == 0);
                n.rw  = n.mr || ($urandom_range(0, 1) == 1);
                fl    = ($urandom_range(0, 7) == 0);
            end else begin
                fl = 1'b0;
            end
            drive(n.rs1, n.rs2, n.rd, n.rw, n.mr, fl);
            ea = model_fwd(hist[2].rs1);
            eb = model_fwd(hist[2].rs2);
            es = model_stall(cur_id);
            checks++; if (bus.fwd_a_o !== ea) begin failures++; $display("[TB] FAIL rand_fwd_a cyc=%0d got=%b exp=%b", i, bus.fwd_a_o, ea); end
            checks++; if (bus.fwd_b_o !== eb) begin failures++; $display("[TB] FAIL rand_fwd_b cyc=%0d got=%b exp=%b", i, bus.fwd_b_o, eb); end
            checks++; if (bus.stall_o !== es) begin failures++; $display("[TB] FAIL rand_stall cyc=%0d got=%b exp=%b", i, bus.stall_o, es); end
            checks++; if (bus.ex_rd_o !== hist[2].rd) begin failures++; $display("[TB] FAIL rand_ex_rd cyc=%0d got=%0d exp=%0d", i, bus.ex_rd_o, hist[2].rd); end
`ifdef FWD_ID_BYPASS_EN
            checks++; if (bus.id_byp_a_o !== (hist[0].rw && hist[0].rd != 5'd0 && hist[0].rd == n.rs1)) begin failures++; $display("[TB] FAIL rand_byp_a cyc=%0d got=%b", i, bus.id_byp_a_o); end
            checks++; if (bus.id_byp_b_o !== (hist[0].rw && hist[0].rd != 5'd0 && hist[0].rd == n.rs2)) begin failures++; $display("[TB] FAIL rand_byp_b cyc=%0d got=%b", i, bus.id_byp_b_o); end
`endif
            held = es && !fl;
            tick();
        end
    endtask

    initial begin
        init_model();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_exmem_forward();
        test_priority();
        test_load_use();
        test_x0_flush();
`ifdef FWD_ID_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
